// File: rtl/bash_f_round_ctrl.sv
// Round sequencer for the bash-f permutation.
// The controller accepts a permutation request and pulses the datapath load.
// It then walks through ROUNDS rounds, supplying the round index and round
// constant for each one. Finally it holds the result valid until it is acked.
// The round constant is stepped by a small combinational bash_f_const stage.

module bash_f_const (
  input  logic [63:0] c_i,
  output logic [63:0] c_o
);

  localparam logic [63:0] POLY = 64'hDC2BE1997FE0D8AE;

  // Byte-order swap between datapath order and the big-endian LFSR view
  function automatic logic [63:0] bswap64(input logic [63:0] x);
    logic [63:0] y;
    y = 64'h0;
    for (int b = 0; b < 8; b++) begin
      y[8*b +: 8] = x[8*(7-b) +: 8];
    end
    return y;
  endfunction

  logic [63:0] be_s;
  logic [63:0] step_s;

  // One LFSR step: shift right, fold the polynomial back in on a carried-out 1
  always_comb begin
    be_s   = bswap64(c_i);
    step_s = {1'b0, be_s[63:1]} ^ (be_s[0] ? POLY : 64'h0);
    c_o    = bswap64(step_s);
  end

endmodule

module bash_f_round_ctrl #(
  parameter int unsigned ROUNDS = 24,
  parameter logic [63:0] C1     = 64'hB194BAC80A08F53B
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        ready_o,
  output logic        load_o,
  input  logic        hold_i,
  input  logic        abort_i,
  output logic        rnd_en_o,
  output logic [4:0]  rnd_idx_o,
  output logic        rnd_last_o,
  output logic [63:0] rnd_const_o,
  output logic        busy_o,
  output logic        valid_o,
  input  logic        ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [4:0] IDX_LAST = 5'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [63:0] cr_q, cr_d;
  logic [63:0] cr_nxt_s;
  logic        is_last_s;

  bash_f_const u_const (
    .c_i (cr_q),
    .c_o (cr_nxt_s)
  );

  assign is_last_s = (idx_q == IDX_LAST);

  // Output decode: ready/busy/valid from state only, round strobe gated by hold
  always_comb begin
    ready_o    = 1'b0;
    rnd_en_o   = 1'b0;
    rnd_last_o = 1'b0;
    busy_o     = 1'b0;
    valid_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
      end
      ST_ROUND: begin
        busy_o     = 1'b1;
        rnd_en_o   = ~hold_i;
        rnd_last_o = is_last_s;
      end
      ST_DONE: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
      end
      default: begin
        ready_o = 1'b0;
      end
    endcase
  end

  // Index and constant are always visible, even outside ROUND
  assign rnd_idx_o   = idx_q;
  assign rnd_const_o = cr_q;

  // Load is gated by reset so a start held during reset never loads the datapath
  assign load_o = ready_o & start_i & ~abort_i & rst_ni;

  // Next-state logic; abort overrides everything and reloads the first constant
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cr_d    = cr_q;
    if (abort_i) begin
      state_d = ST_IDLE;
      idx_d   = 5'd0;
      cr_d    = C1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_ROUND;
            idx_d   = 5'd0;
            cr_d    = C1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ROUND: begin
          if (hold_i) begin
            state_d = ST_ROUND;
          end else if (is_last_s) begin
            // the last constant stays visible through DONE
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 5'd1;
            cr_d  = cr_nxt_s;
          end
        end
        ST_DONE: begin
          if (ack_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, round counter and constant register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      cr_q    <= C1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cr_q    <= cr_d;
    end
  end

endmodule

// File: tb/tb_bash_f_round_ctrl.sv
// Scoreboard bench for bash_f_round_ctrl.
// The stimulus side plans each permutation and pushes expected events into queues.
// A negedge monitor pops those events and compares them with DUT outputs.
module tb_bash_f_round_ctrl;

  localparam int          ROUNDS = 24;
  localparam logic [63:0] C1     = 64'hB194BAC80A08F53B;
  localparam logic [63:0] C2_DP  = 64'hF692BD1B9C65D1C1;
  localparam logic [63:0] POLY   = 64'hDC2BE1997FE0D8AE;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b1;
  logic        start_i = 1'b0;
  logic        hold_i  = 1'b0;
  logic        abort_i = 1'b0;
  logic        ack_i   = 1'b0;
  logic        ready_o, load_o, rnd_en_o, rnd_last_o, busy_o, valid_o;
  logic [4:0]  rnd_idx_o;
  logic [63:0] rnd_const_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {int cyc; logic [4:0] idx; logic [63:0] k; logic lst;} rnd_t;
  typedef struct {int rise; int fall;} res_t;
  typedef struct {
    int cyc; logic rdy; logic bsy; logic vld; logic en; logic lst; logic ld;
    logic [4:0] idx; logic [63:0] k;
  } snap_t;

  rnd_t  rnd_q[$];
  res_t  res_q[$];
  snap_t snap_q[$];
  int    load_q[$];

  logic [63:0] consts [ROUNDS];
  int          hold_plan [ROUNDS];
  logic [4:0]  last_idx = 5'd0;
  logic [63:0] last_c   = 64'd0;
  int          fall_exp = -1;
  logic        valid_prev = 1'b0;

  bash_f_round_ctrl #(.ROUNDS(ROUNDS), .C1(C1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ready_o(ready_o),
    .load_o(load_o), .hold_i(hold_i), .abort_i(abort_i), .rnd_en_o(rnd_en_o),
    .rnd_idx_o(rnd_idx_o), .rnd_last_o(rnd_last_o), .rnd_const_o(rnd_const_o),
    .busy_o(busy_o), .valid_o(valid_o), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [63:0] byterev(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 8; i++) y = (y << 8) | ((x >> (8 * i)) & 64'hFF);
    return y;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic void exp_snap(input int c, input logic rdy, input logic bsy,
                                   input logic vld, input logic en, input logic lst,
                                   input logic ld, input logic [4:0] idx, input logic [63:0] k);
    snap_t s;
    s = '{cyc: c, rdy: rdy, bsy: bsy, vld: vld, en: en, lst: lst, ld: ld, idx: idx, k: k};
    snap_q.push_back(s);
  endfunction

  task automatic monitor_cycle();
    rnd_t  r;
    res_t  x;
    snap_t s;
    if (load_o === 1'b1) begin
      if (load_q.size() == 0) chk("load_unexpected", {63'd0, load_o}, 64'd0);
      else chk("load_cycle", 64'(cyc), 64'(load_q.pop_front()));
    end
    if (rnd_en_o === 1'b1) begin
      if (rnd_q.size() == 0) chk("round_unexpected", {63'd0, rnd_en_o}, 64'd0);
      else begin
        r = rnd_q.pop_front();
        chk("round_cycle", 64'(cyc), 64'(r.cyc));
        chk("round_idx", 64'(rnd_idx_o), 64'(r.idx));
        chk("round_const", rnd_const_o, r.k);
        chk("round_last", 64'(rnd_last_o), 64'(r.lst));
      end
    end
    if (valid_o === 1'b1 && !valid_prev) begin
      if (res_q.size() == 0) chk("valid_unexpected", {63'd0, valid_o}, 64'd0);
      else begin
        x = res_q.pop_front();
        chk("valid_rise", 64'(cyc), 64'(x.rise));
        fall_exp = x.fall;
      end
    end else if (valid_o !== 1'b1 && valid_prev) begin
      chk("valid_fall", 64'(cyc), 64'(fall_exp));
      fall_exp = -1;
    end
    valid_prev = (valid_o === 1'b1);
    while (snap_q.size() > 0 && snap_q[0].cyc < cyc) begin
      s = snap_q.pop_front();
      chk("snap_missed", 64'(cyc), 64'(s.cyc));
    end
    if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
      s = snap_q.pop_front();
      chk("snap_ready", 64'(ready_o), 64'(s.rdy));
      chk("snap_busy", 64'(busy_o), 64'(s.bsy));
      chk("snap_valid", 64'(valid_o), 64'(s.vld));
      chk("snap_rnd_en", 64'(rnd_en_o), 64'(s.en));
      chk("snap_rnd_last", 64'(rnd_last_o), 64'(s.lst));
      chk("snap_load", 64'(load_o), 64'(s.ld));
      chk("snap_idx", 64'(rnd_idx_o), 64'(s.idx));
      chk("snap_const", rnd_const_o, s.k);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      monitor_cycle();
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // kill: 0 none, 1 abort at round kill_rnd, 2 async reset at round kill_rnd
  task automatic run_op(input int idle_pre, input bit sa_idle, input int kill, input int kill_rnd,
                        input int ack_dly, input bit start_in_done, input bit lit_chk);
    int t0;
    int hs;
    int e;
    for (int i = 0; i < idle_pre; i++) begin
      start_i = (sa_idle && i == 0);
      abort_i = (sa_idle && i == 0);
      hold_i  = rbit();
      ack_i   = rbit();
      exp_snap(cyc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_idx, last_c);
      step();
      if (sa_idle && i == 0) begin
        last_idx = 5'd0;
        last_c   = C1;
      end
    end
    start_i = 1'b1; abort_i = 1'b0; hold_i = rbit(); ack_i = rbit();
    t0 = cyc;
    load_q.push_back(t0);
    exp_snap(t0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last_idx, last_c);
    step();
    hs = 0;
    for (int k = 0; k < ROUNDS; k++) begin
      for (int j = 0; j < hold_plan[k]; j++) begin
        hold_i = 1'b1; start_i = rbit(); ack_i = rbit(); abort_i = 1'b0;
        exp_snap(t0 + 1 + k + hs, 1'b0, 1'b1, 1'b0, 1'b0, (k == ROUNDS - 1), 1'b0, 5'(k), consts[k]);
        hs++;
        step();
      end
      hold_i = 1'b0; start_i = rbit(); ack_i = rbit(); abort_i = 1'b0;
      if (kill == 2 && k == kill_rnd) begin
        rst_ni = 1'b0;
        exp_snap(cyc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, C1);
        step();
        exp_snap(cyc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, C1);
        step();
        rst_ni = 1'b1; start_i = 1'b0; ack_i = 1'b0;
        last_idx = 5'd0; last_c = C1;
        return;
      end
      rnd_q.push_back(rnd_t'{t0 + 1 + k + hs, 5'(k), consts[k], (k == ROUNDS - 1)});
      if (lit_chk && k < 2)
        exp_snap(t0 + 1 + k + hs, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'(k), (k == 0) ? C1 : C2_DP);
      if (kill == 1 && k == kill_rnd) begin
        abort_i = 1'b1;
        step();
        abort_i = 1'b0; start_i = 1'b0; ack_i = 1'b0;
        last_idx = 5'd0; last_c = C1;
        return;
      end
      step();
    end
    e = t0 + ROUNDS + 1 + hs;
    res_q.push_back(res_t'{e, e + ack_dly + 1});
    for (int i = 0; i < ack_dly; i++) begin
      ack_i = 1'b0; start_i = start_in_done ? 1'b1 : rbit(); hold_i = rbit(); abort_i = 1'b0;
      exp_snap(e + i, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'(ROUNDS - 1), consts[ROUNDS - 1]);
      step();
    end
    ack_i = 1'b1; start_i = 1'b0;
    exp_snap(e + ack_dly, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'(ROUNDS - 1), consts[ROUNDS - 1]);
    step();
    ack_i = 1'b0; hold_i = 1'b0;
    last_idx = 5'(ROUNDS - 1);
    last_c   = consts[ROUNDS - 1];
  endtask

  task automatic clear_plan();
    for (int k = 0; k < ROUNDS; k++) hold_plan[k] = 0;
  endtask

  initial begin
    logic [63:0] kbe;
    int r;
    kbe = byterev(C1);
    for (int i = 0; i < ROUNDS; i++) begin
      consts[i] = byterev(kbe);
      kbe = (kbe >> 1) ^ (kbe[0] ? POLY : 64'd0);
    end

    // reset with start held high: load must stay low
    rst_ni = 1'b0; start_i = 1'b1;
    step();
    exp_snap(cyc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, C1);
    step();
    exp_snap(cyc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, C1);
    step();
    rst_ni = 1'b1; start_i = 1'b0;
    last_idx = 5'd0; last_c = C1;

    clear_plan();
    run_op(0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    hold_plan[5] = 3;
    run_op(0, 1'b0, 0, 0, 10, 1'b1, 1'b0);
    clear_plan();
    run_op(0, 1'b0, 1, 10, 2, 1'b0, 1'b0);
    run_op(2, 1'b1, 0, 0, 1, 1'b0, 1'b0);
    run_op(1, 1'b0, 2, 12, 0, 1'b0, 1'b0);
    run_op(0, 1'b0, 0, 0, 0, 1'b0, 1'b1);

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < ROUNDS; k++)
        hold_plan[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      r = int'($urandom_range(0, 9));
      run_op(int'($urandom_range(0, 3)), rbit(), (r < 2) ? 1 : ((r == 2) ? 2 : 0),
             int'($urandom_range(0, ROUNDS - 1)), int'($urandom_range(0, 5)), rbit(), 1'b0);
    end

    start_i = 1'b0; hold_i = 1'b0; ack_i = 1'b0; abort_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_snap(cyc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_idx, last_c);
      step();
    end
    @(negedge clk_i);
    #1;
    chk("rounds_left", 64'(rnd_q.size()), 64'd0);
    chk("results_left", 64'(res_q.size()), 64'd0);
    chk("loads_left", 64'(load_q.size()), 64'd0);
    chk("snaps_left", 64'(snap_q.size()), 64'd0);
    chk("valid_still_pending", 64'(fall_exp + 1), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bash_f_round_ctrl.md
# bash_f_round_ctrl

Round sequencer for the bash-f permutation. It accepts a permutation request and tells the round datapath when to load its state and when to run each of the rounds. For every round it supplies the round index and the round constant, and it steps the constant through a `bash_f_const` instance. Backpressure is handled with a start/ready handshake on the input side and a valid/ack handshake on the result side, plus a hold input and an abort input.

## Interface
- `ROUNDS`, 24: rounds per permutation. Legal range 1..31.
- `C1`, 64'hB194BAC80A08F53B: first round constant in datapath byte order. This is the byte-reverse of 0x3BF5080AC8BA94B1.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: request a permutation.
- `ready_o` out 1: controller idle and able to accept a request.
- `load_o` out 1: datapath captures the input state this cycle.
- `hold_i` in 1: freeze round progress this cycle.
- `abort_i` in 1: cancel the current operation.
- `rnd_en_o` out 1: datapath applies one round this cycle.
- `rnd_idx_o` out 5: index of the current round, 0..ROUNDS-1.
- `rnd_last_o` out 1: current round is the final one.
- `rnd_const_o` out 64: constant for the current round, in datapath byte order.
- `busy_o` out 1: a request is in progress (ROUND or DONE state).
- `valid_o` out 1: permutation result is valid in the datapath.
- `ack_i` in 1: consumer has taken the result.

## Operation
- States:
  - IDLE (reset state).
  - ROUND.
  - DONE.
- Registers:
  - state.
  - 5-bit round counter `idx`.
  - 64-bit constant register `cr`.
- IDLE:
  - `ready_o` = 1.
  - Acceptance is `start_i & ready_o & ~abort_i`. When it occurs, `load_o` = 1 combinationally in the same cycle.
  - On acceptance at the next edge: state <= ROUND, `idx` <= 0, `cr` <= C1.
- ROUND:
  - `rnd_en_o = ~hold_i`.
  - `rnd_idx_o = idx`.
  - `rnd_const_o = cr`.
  - `rnd_last_o = (idx == ROUNDS-1)`.
  - Edge with `hold_i` = 0 and not last round: `idx` <= idx+1, `cr` <= `bash_f_const(cr)`.
  - Edge with `hold_i` = 0 and last round: state <= DONE. `cr` is not updated.
  - Edge with `hold_i` = 1: all registers keep their values.
- DONE:
  - `valid_o` = 1 until an edge with `ack_i` = 1, then state <= IDLE.
  - `ready_o` = 0 in DONE. A new request is accepted one cycle after the ack at the earliest.
- `abort_i`:
  - Highest priority in every state. Next state is IDLE, `idx` <= 0, `cr` <= C1.
  - In ROUND, `rnd_en_o` is still driven by `hold_i` during the abort cycle. The datapath must treat its contents as discarded.
  - In IDLE, abort blocks acceptance: `load_o` = 0.
- In states other than ROUND: `rnd_en_o`, `rnd_last_o` = 0; `rnd_idx_o` = `idx`; `rnd_const_o` = `cr`.
- `ack_i` outside DONE, and `start_i` outside IDLE, are ignored.
- The constant recurrence is the one implemented by `bash_f_const`: byte-reverse, shift right by 1, XOR 0xDC2BE1997FE0D8AE when the shifted-out LSB was 1, byte-reverse back.

## Timing
- Reset (`rst_ni` low):
  - state IDLE, `idx` 0, `cr` C1.
  - `ready_o` = 1.
  - `load_o` = 0: gated by `rst_ni` while reset is asserted.
  - `rnd_en_o`, `rnd_last_o`, `busy_o`, `valid_o` = 0.
  - `rnd_idx_o` = 0, `rnd_const_o` = C1.
- Release is synchronous to the first `clk_i` edge with `rst_ni` high. Reset asserted mid-operation returns immediately to the IDLE values.
- Latency with no hold, acceptance in cycle T:
  - rounds run in cycles T+1 .. T+ROUNDS;
  - `valid_o` rises in cycle T+ROUNDS+1.
- Each hold cycle adds exactly one cycle of latency.
- ROUNDS = 1: a single ROUND cycle with `rnd_last_o` = 1.
- No combinational path from `ack_i` to any output.
- `ready_o` depends only on state. `load_o` depends on state, `start_i`, `abort_i` and `rst_ni`.

## Test plan
- Reset, then start pulse at cycle 0:
  - `load_o` = 1 at cycle 0.
  - `rnd_en_o` high cycles 1-24.
  - `rnd_idx_o` counts 0..23.
  - `rnd_last_o` only at idx 23.
  - `valid_o` = 1 at cycle 25.
- Constants:
  - idx 0: `rnd_const_o` = 0xB194BAC80A08F53B.
  - idx 1: `rnd_const_o` = 0xF692BD1B9C65D1C1 (byte-reverse of C2 = 0xC1D1659C1BBD92F6).
  - Full 24-constant sequence matches the software model.
- `hold_i` high for 3 cycles at idx 5:
  - `idx` and `cr` frozen during the hold.
  - `rnd_en_o` = 0 during the hold.
  - `valid_o` at cycle 28.
- DONE with `ack_i` low for 10 cycles:
  - `valid_o` held.
  - `start_i` high is ignored: `ready_o` = 0, `load_o` = 0.
  - Ack takes the controller to IDLE; a new start is accepted on the next cycle.
- Abort:
  - `abort_i` at idx 10 → IDLE next cycle, `rnd_idx_o` = 0, `rnd_const_o` = C1, `valid_o` never asserted.
  - `start_i` and `abort_i` together in IDLE → `load_o` = 0 and no operation starts.
- Async reset mid-round (idx 12), released, then a new start → identical to the first scenario.
